// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: access sizes, wait-state FSM states and the
// byte-lane enable helper, also used by the decoder.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_t;

    // Lane enables for a store; size 2'b10 falls through to a full word.
    function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                               input logic [1:0] lo,
                                               input logic       big_endian);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lo;
            SIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        if (big_endian) be = {be[0], be[1], be[2], be[3]};
        return be;
    endfunction

endpackage

// File: rtl/word_ram_be.sv
// Word-organised data RAM with per-lane write enables, an asynchronous data
// read port and a registered debug read port.
module word_ram_be #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        we,
    input  logic [ADDR_W-3:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic              dbg_en,
    input  logic [ADDR_W-3:0] dbg_addr,
    output logic [31:0]       dbg_data
);
    localparam int DEPTH = 1 << (ADDR_W - 2);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (reset)       dbg_data <= 32'd0;
        else if (dbg_en) dbg_data <= mem[dbg_addr];
    end

endmodule

// File: rtl/mem_stage_ws.sv
// MIPS MEM stage with configurable wait states, byte-lane RAM, selectable
// endianness, misalignment trapping and a halted-mode debug read port.
module mem_stage_ws
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 0,
    parameter int BIG_ENDIAN  = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_halt,
    input  logic [4:0]        i_write_reg,
    input  logic [31:0]       i_store_data,
    input  logic [31:0]       i_alu_result,
    input  logic              i_wb_write,
    input  logic              i_wb_mem_to_reg,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_mem_unsigned,
    input  logic [1:0]        i_mem_size,
    output logic              o_stall,
    output logic              o_wb_write,
    output logic              o_wb_mem_to_reg,
    output logic [31:0]       o_alu_result,
    output logic [31:0]       o_read_data,
    output logic [4:0]        o_write_reg,
    output logic              o_misaligned,
    output logic [31:0]       o_bad_addr,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [31:0]       o_dbg_data,
    output logic              o_dbg_valid
);
    localparam logic [3:0] WAIT_LD  = 4'(WAIT_CYCLES);
    localparam logic       BE_MODE  = (BIG_ENDIAN != 0);
    localparam logic       HAS_WAIT = (WAIT_CYCLES != 0);

    logic [1:0]        lo;
    logic [ADDR_W-3:0] word_addr;
    logic              mem_op;
    logic              misal;
    logic              stall_now;
    logic              stall_q;
    mem_state_t        state;
    logic [3:0]        cnt;
    logic [3:0]        lane_we;
    logic [31:0]       rd_word;
    logic              unused_bits;

    function automatic logic [31:0] replicate_store(input logic [31:0] data,
                                                    input logic [1:0]  size);
        case (size)
            SIZE_BYTE: return {4{data[7:0]}};
            SIZE_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  addr_lo,
                                                input logic        uns);
        logic [1:0]        lane;
        logic signed [7:0] b;
        logic signed [15:0] h;
        lane = BE_MODE ? ~addr_lo : addr_lo;
        b    = word[{lane, 3'b000} +: 8];
        h    = (addr_lo[1] ^ BE_MODE) ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: return uns ? {24'd0, b} : {{24{b[7]}}, b};
            SIZE_HALF: return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default:   return word;
        endcase
    endfunction

    assign lo          = i_alu_result[1:0];
    assign word_addr   = i_alu_result[ADDR_W-1:2];
    assign unused_bits = ^{i_alu_result[31:ADDR_W], i_dbg_addr[1:0]};
    assign mem_op      = i_mem_read | i_mem_write;
    assign misal       = mem_op && (((i_mem_size == SIZE_HALF) && lo[0]) ||
                                    (i_mem_size[1] && (lo != 2'b00)));

    // BUSY holds the op until the decremented count would hit zero.
    always_comb begin
        stall_now = 1'b0;
        if (state == ST_BUSY) stall_now = (cnt != 4'd1);
        else                  stall_now = HAS_WAIT && mem_op && !misal;
    end

    assign o_stall = i_halt ? stall_q : stall_now;

    // Stores commit only on the completing, non-halted, non-reset edge.
    assign lane_we = (i_mem_write && !misal && !stall_now && !i_halt && !i_reset)
                   ? byte_enable(i_mem_size, lo, BE_MODE) : 4'b0000;

    word_ram_be #(.ADDR_W(ADDR_W)) ram (
        .clk      (i_clk),
        .reset    (i_reset),
        .we       (lane_we),
        .addr     (word_addr),
        .wdata    (replicate_store(i_store_data, i_mem_size)),
        .rdata    (rd_word),
        .dbg_en   (i_halt),
        .dbg_addr (i_dbg_addr[ADDR_W-1:2]),
        .dbg_data (o_dbg_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            stall_q <= 1'b0;
        end else if (!i_halt) begin
            stall_q <= stall_now;
            case (state)
                ST_IDLE: begin
                    if (HAS_WAIT && mem_op && !misal) begin
                        state <= ST_BUSY;
                        cnt   <= WAIT_LD;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, frozen while halted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_write      <= 1'b0;
            o_wb_mem_to_reg <= 1'b0;
            o_alu_result    <= 32'd0;
            o_read_data     <= 32'd0;
            o_write_reg     <= 5'd0;
            o_misaligned    <= 1'b0;
            o_bad_addr      <= 32'd0;
            o_dbg_valid     <= 1'b0;
        end else begin
            o_dbg_valid <= i_halt;
            if (!i_halt) begin
                if (stall_now) begin
                    o_wb_write   <= 1'b0;
                    o_misaligned <= 1'b0;
                end else begin
                    o_wb_write      <= i_wb_write && !misal;
                    o_wb_mem_to_reg <= i_wb_mem_to_reg;
                    o_alu_result    <= i_alu_result;
                    o_read_data     <= (i_mem_read && !misal)
                                     ? extend_load(rd_word, i_mem_size, lo, i_mem_unsigned)
                                     : 32'd0;
                    o_write_reg     <= i_write_reg;
                    o_misaligned    <= misal;
                    if (misal) o_bad_addr <= i_alu_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ws.sv
// Scoreboard bench for mem_stage_ws across three parameter sets:
// dut0 (0 waits, little-endian), dut1 (2 waits, big-endian), dut2 (3 waits, little-endian).
module tb_mem_stage_ws;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b11;

    typedef struct packed {
        logic        wbw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] rd;
        logic        chk_rd;
        logic [4:0]  wr;
        logic        mis;
        logic [31:0] bad;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, halt_s;
    logic [1:0]  sel;
    logic [4:0]  write_reg;
    logic [31:0] store_data, alu;
    logic        wbw, m2r, mrd, mwr, uns;
    logic [1:0]  size;
    logic [11:0] dbg_addr;
    logic [2:0]  halt_v, rd_v, wr_v;

    logic        stall_o [3];
    logic        wbw_o   [3];
    logic        m2r_o   [3];
    logic        mis_o   [3];
    logic        dbgv_o  [3];
    logic [31:0] alu_o   [3];
    logic [31:0] rd_o    [3];
    logic [31:0] bad_o   [3];
    logic [31:0] dbg_o   [3];
    logic [4:0]  wr_o    [3];

    int          tests = 0;
    int          fails = 0;
    exp_t        q[$];
    string       nq[$];
    logic [31:0] exp_bad [3];
    int          n;

    always #5 clk = ~clk;

    assign halt_v = {3{halt_s}} & (3'b001 << sel);
    assign rd_v   = {3{mrd}}    & (3'b001 << sel);
    assign wr_v   = {3{mwr}}    & (3'b001 << sel);

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int WC = (k == 0) ? 0 : ((k == 1) ? 2 : 3);
        localparam int BE = (k == 1) ? 1 : 0;
        mem_stage_ws #(.ADDR_W(12), .WAIT_CYCLES(WC), .BIG_ENDIAN(BE)) dut (
            .i_clk           (clk),
            .i_reset         (reset),
            .i_halt          (halt_v[k]),
            .i_write_reg     (write_reg),
            .i_store_data    (store_data),
            .i_alu_result    (alu),
            .i_wb_write      (wbw),
            .i_wb_mem_to_reg (m2r),
            .i_mem_read      (rd_v[k]),
            .i_mem_write     (wr_v[k]),
            .i_mem_unsigned  (uns),
            .i_mem_size      (size),
            .o_stall         (stall_o[k]),
            .o_wb_write      (wbw_o[k]),
            .o_wb_mem_to_reg (m2r_o[k]),
            .o_alu_result    (alu_o[k]),
            .o_read_data     (rd_o[k]),
            .o_write_reg     (wr_o[k]),
            .o_misaligned    (mis_o[k]),
            .o_bad_addr      (bad_o[k]),
            .i_dbg_addr      (dbg_addr),
            .o_dbg_data      (dbg_o[k]),
            .o_dbg_valid     (dbgv_o[k])
        );
    end

    // Monitor: bubbles while stalled, scoreboard pop on each tagged completion.
    always @(posedge clk) begin
        logic [1:0] s;
        logic       st, tag, active;
        exp_t       e;
        string      nm;
        s      = sel;
        st     = stall_o[sel];
        tag    = (write_reg != 5'd0);
        active = !reset && !halt_v[sel];
        if (active && (st || tag)) begin
            #1;
            tests++;
            if (st) begin
                if (wbw_o[s] !== 1'b0 || mis_o[s] !== 1'b0) begin
                    fails++;
                    $display("FAIL bubble dut%0d: wb_write=%0d misaligned=%0d, expected 0/0",
                             s, wbw_o[s], mis_o[s]);
                end
            end else if (q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_underflow dut%0d: output with no expected entry", s);
            end else begin
                e  = q.pop_front();
                nm = nq.pop_front();
                if (wbw_o[s] !== e.wbw || m2r_o[s] !== e.m2r || alu_o[s] !== e.alu ||
                    (e.chk_rd && rd_o[s] !== e.rd) || wr_o[s] !== e.wr ||
                    mis_o[s] !== e.mis || bad_o[s] !== e.bad) begin
                    fails++;
                    $display("FAIL %s: got wb=%0d m2r=%0d alu=%h rd=%h wr=%0d mis=%0d bad=%h; expected wb=%0d m2r=%0d alu=%h rd=%h wr=%0d mis=%0d bad=%h",
                             nm, wbw_o[s], m2r_o[s], alu_o[s], rd_o[s], wr_o[s], mis_o[s], bad_o[s],
                             e.wbw, e.m2r, e.alu, e.rd, e.wr, e.mis, e.bad);
                end
            end
        end
    end

    task automatic drive_nop();
        mrd = 1'b0; mwr = 1'b0; wbw = 1'b0; m2r = 1'b0; uns = 1'b0;
        size = SZ_W; alu = 32'd0; store_data = 32'd0; write_reg = 5'd0;
    endtask

    task automatic check_zero(input int k, input string nm);
        tests++;
        if ({stall_o[k], wbw_o[k], m2r_o[k], mis_o[k], dbgv_o[k]} !== 5'b0 ||
            alu_o[k] !== 32'd0 || rd_o[k] !== 32'd0 || wr_o[k] !== 5'd0 ||
            bad_o[k] !== 32'd0 || dbg_o[k] !== 32'd0) begin
            fails++;
            $display("FAIL %s dut%0d: stall=%0d wb=%0d m2r=%0d mis=%0d dv=%0d alu=%h rd=%h wr=%0d bad=%h dbg=%h, expected all 0",
                     nm, k, stall_o[k], wbw_o[k], m2r_o[k], mis_o[k], dbgv_o[k],
                     alu_o[k], rd_o[k], wr_o[k], bad_o[k], dbg_o[k]);
        end
    endtask

    task automatic check_stalls(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: non-halted stall cycles %0d, expected %0d", nm, got, want);
        end
    endtask

    // Called at a negedge; returns at the negedge after the completion edge.
    task automatic issue(input string nm, input logic r, input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a, input logic [31:0] d,
                         input logic wb, input logic [4:0] wreg, input logic [31:0] exp_rd,
                         input logic exp_mis, input int halt_after, input int halt_len,
                         output int stalls);
        exp_t e;
        bit   pend, done;
        int   hc;
        mrd = r; mwr = w; size = sz; uns = u; alu = a; store_data = d;
        wbw = wb; m2r = r; write_reg = wreg;
        if (exp_mis) exp_bad[sel] = a;
        e = '{wbw: wb && !exp_mis, m2r: r, alu: a, rd: exp_rd, chk_rd: r || exp_mis,
              wr: wreg, mis: exp_mis, bad: exp_bad[sel]};
        q.push_back(e);
        nq.push_back(nm);
        stalls = 0; pend = (halt_after >= 0); hc = 0; done = 1'b0;
        for (int g = 0; g < 64 && !done; g++) begin
            if (pend && stalls == halt_after) begin
                halt_s = 1'b1; hc = halt_len; pend = 1'b0;
            end
            #1;
            if (halt_s) begin
                tests++;
                if (stall_o[sel] !== 1'b1) begin
                    fails++;
                    $display("FAIL %s halt_stall_hold: stall=%0d, expected 1", nm, stall_o[sel]);
                end
                if (hc < halt_len) begin
                    tests++;
                    if (dbg_o[sel] !== 32'hDEADBEEF || dbgv_o[sel] !== 1'b1) begin
                        fails++;
                        $display("FAIL %s debug_read: data=%h valid=%0d, expected deadbeef/1",
                                 nm, dbg_o[sel], dbgv_o[sel]);
                    end
                end
                hc--;
                @(negedge clk);
                if (hc == 0) halt_s = 1'b0;
            end else if (stall_o[sel]) begin
                stalls++;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s timeout: stall never released", nm);
        end
        @(negedge clk);
        drive_nop();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; halt_s = 1'b0; sel = 2'd0; dbg_addr = 12'h010;
        drive_nop();
        for (int k = 0; k < 3; k++) exp_bad[k] = 32'd0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check_zero(k, "reset_state");
        reset = 1'b0;
        @(negedge clk);

        // dut0: no waits, little-endian byte/half lanes and extension
        sel = 2'd0;
        issue("sw_zero_004", 0, 1, SZ_W, 0, 32'h004, 32'h0,        0, 5'd1, 32'h0,        0, -1, 0, n);
        issue("sb_80_005",   0, 1, SZ_B, 0, 32'h005, 32'hABCDEF80, 0, 5'd2, 32'h0,        0, -1, 0, n);
        issue("lb_005",      1, 0, SZ_B, 0, 32'h005, 32'h0,        1, 5'd3, 32'hFFFFFF80, 0, -1, 0, n);
        issue("lbu_005",     1, 0, SZ_B, 1, 32'h005, 32'h0,        1, 5'd4, 32'h00000080, 0, -1, 0, n);
        issue("lw_004",      1, 0, SZ_W, 0, 32'h004, 32'h0,        1, 5'd5, 32'h00008000, 0, -1, 0, n);
        issue("lh_004",      1, 0, SZ_H, 0, 32'h004, 32'h0,        1, 5'd6, 32'hFFFF8000, 0, -1, 0, n);
        issue("lhu_004",     1, 0, SZ_H, 1, 32'h004, 32'h0,        1, 5'd7, 32'h00008000, 0, -1, 0, n);
        issue("lw_006_mis",  1, 0, SZ_W, 0, 32'h006, 32'h0,        1, 5'd8, 32'h0,        1, -1, 0, n);
        issue("sh_005_mis",  0, 1, SZ_H, 0, 32'h005, 32'h0000FFFF, 0, 5'd9, 32'h0,        1, -1, 0, n);
        issue("lw_004_kept", 1, 0, SZ_W, 0, 32'h004, 32'h0,        1, 5'd10, 32'h00008000, 0, -1, 0, n);
        issue("alu_pass",    0, 0, SZ_W, 0, 32'h12345678, 32'h0,   1, 5'd11, 32'h0,       0, -1, 0, n);

        // dut1: two waits, big-endian
        sel = 2'd1;
        issue("sw_deadbeef_010", 0, 1, SZ_W, 0, 32'h010, 32'hDEADBEEF, 0, 5'd12, 32'h0, 0, -1, 0, n);
        check_stalls("sw_010_stall", n, 2);
        issue("lw_010",      1, 0, SZ_W, 0, 32'h010, 32'h0,        1, 5'd13, 32'hDEADBEEF, 0, -1, 0, n);
        check_stalls("lw_010_stall", n, 2);
        issue("sw_zero_000", 0, 1, SZ_W, 0, 32'h000, 32'h0,        0, 5'd14, 32'h0,        0, -1, 0, n);
        issue("sh_1234_002", 0, 1, SZ_H, 0, 32'h002, 32'hAAAA1234, 0, 5'd15, 32'h0,        0, -1, 0, n);
        issue("lw_000_be",   1, 0, SZ_W, 0, 32'h000, 32'h0,        1, 5'd16, 32'h00001234, 0, -1, 0, n);
        issue("lhu_002_be",  1, 0, SZ_H, 1, 32'h002, 32'h0,        1, 5'd17, 32'h00001234, 0, -1, 0, n);
        issue("lb_003_be",   1, 0, SZ_B, 0, 32'h003, 32'h0,        1, 5'd18, 32'h00000034, 0, -1, 0, n);
        issue("lb_002_be",   1, 0, SZ_B, 0, 32'h002, 32'h0,        1, 5'd19, 32'h00000012, 0, -1, 0, n);
        issue("lh_000_be",   1, 0, SZ_H, 0, 32'h000, 32'h0,        1, 5'd20, 32'h00000000, 0, -1, 0, n);

        // dut2: three waits, misaligned bypass, halt mid-BUSY, reset mid-BUSY
        sel = 2'd2;
        issue("sw_deadbeef_010_w3", 0, 1, SZ_W, 0, 32'h010, 32'hDEADBEEF, 0, 5'd21, 32'h0, 0, -1, 0, n);
        check_stalls("sw_010_w3_stall", n, 3);
        issue("lw_006_mis_w3", 1, 0, SZ_W, 0, 32'h006, 32'h0, 1, 5'd22, 32'h0, 1, -1, 0, n);
        check_stalls("mis_no_stall", n, 0);
        issue("sw_halted_030", 0, 1, SZ_W, 0, 32'h030, 32'h0A0B0C0D, 0, 5'd23, 32'h0, 0, 1, 5, n);
        check_stalls("halted_stall", n, 3);
        issue("lw_030",      1, 0, SZ_W, 0, 32'h030, 32'h0, 1, 5'd24, 32'h0A0B0C0D, 0, -1, 0, n);
        check_stalls("lw_030_stall", n, 3);
        issue("sw_1111_020", 0, 1, SZ_W, 0, 32'h020, 32'h11111111, 0, 5'd25, 32'h0, 0, -1, 0, n);

        // store abandoned by reset on what would have been its completion cycle
        mwr = 1'b1; size = SZ_W; alu = 32'h020; store_data = 32'h00000055; write_reg = 5'd26;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive_nop();
        for (int k = 0; k < 3; k++) exp_bad[k] = 32'd0;
        #1;
        check_zero(2, "reset_mid_busy");
        @(negedge clk);
        issue("lw_020_kept", 1, 0, SZ_W, 0, 32'h020, 32'h0, 1, 5'd27, 32'h11111111, 0, -1, 0, n);
        sel = 2'd0;
        issue("lw_004_after_reset", 1, 0, SZ_W, 0, 32'h004, 32'h0, 1, 5'd28, 32'h00008000, 0, -1, 0, n);

        repeat (2) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expected entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
